// File: rtl/fk_history_seq_if.sv
// Sample/tap bus between the fk history sequencer and its producer/consumers.
// FK_OVERRUN_EN adds the sticky overrun flag to the bus.
interface fk_history_seq_if #(
    parameter int unsigned WIDTH = 25
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             clear;
    logic             ready;
    logic [WIDTH-1:0] fk;
    logic [WIDTH-1:0] fk_1;
    logic [WIDTH-1:0] fk_2;
    logic [1:0]       select;
    logic             tap_valid;
    logic             done;
`ifdef FK_OVERRUN_EN
    logic             overrun;
`endif

    modport master (
        output sample_in, sample_valid, clear,
`ifdef FK_OVERRUN_EN
        input  overrun,
`endif
        input  ready, fk, fk_1, fk_2, select, tap_valid, done
    );

    modport slave (
        input  sample_in, sample_valid, clear,
`ifdef FK_OVERRUN_EN
        output overrun,
`endif
        output ready, fk, fk_1, fk_2, select, tap_valid, done
    );
endinterface

// File: rtl/fk_history_seq.sv
// 3-deep sample history with a 3-tap select sequencer feeding Mux_Fk and the MAC.
// FK_OVERRUN_EN adds a sticky flag for samples offered while busy.
module fk_history_seq #(
    parameter int unsigned WIDTH = 25
) (
    input logic              clk,
    input logic              reset,
    fk_history_seq_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StTap0, StTap1, StTap2, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fk_q, fk_d, fk1_q, fk1_d, fk2_q, fk2_d;
    logic             ready_q, ready_d;
    logic             tap_valid_q, tap_valid_d;
    logic             done_q, done_d;
    logic [1:0]       select_q, select_d;

    always_comb begin
        state_d = state_q;
        fk_d    = fk_q;
        fk1_d   = fk1_q;
        fk2_d   = fk2_q;
        unique case (state_q)
            StIdle: begin
                if (bus.sample_valid) begin
                    fk2_d   = fk1_q;
                    fk1_d   = fk_q;
                    fk_d    = bus.sample_in;
                    state_d = StTap0;
                end
            end
            StTap0:  state_d = StTap1;
            StTap1:  state_d = StTap2;
            StTap2:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Clear beats any accept in the same cycle and skips the done pulse.
        if (bus.clear) begin
            state_d = StIdle;
            fk_d    = '0;
            fk1_d   = '0;
            fk2_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ready_d     = 1'b0;
        tap_valid_d = 1'b0;
        select_d    = 2'b00;
        done_d      = 1'b0;
        unique case (state_d)
            StIdle: ready_d = 1'b1;
            StTap0: tap_valid_d = 1'b1;
            StTap1: begin
                tap_valid_d = 1'b1;
                select_d    = 2'b01;
            end
            StTap2: begin
                tap_valid_d = 1'b1;
                select_d    = 2'b10;
            end
            StDone:  done_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fk_q        <= '0;
            fk1_q       <= '0;
            fk2_q       <= '0;
            ready_q     <= 1'b1;
            tap_valid_q <= 1'b0;
            select_q    <= 2'b00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fk_q        <= fk_d;
            fk1_q       <= fk1_d;
            fk2_q       <= fk2_d;
            ready_q     <= ready_d;
            tap_valid_q <= tap_valid_d;
            select_q    <= select_d;
            done_q      <= done_d;
        end
    end

`ifdef FK_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q | (bus.sample_valid & ~ready_q);
        if (bus.clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`endif

    assign bus.ready     = ready_q;
    assign bus.fk        = fk_q;
    assign bus.fk_1      = fk1_q;
    assign bus.fk_2      = fk2_q;
    assign bus.select    = select_q;
    assign bus.tap_valid = tap_valid_q;
    assign bus.done      = done_q;
endmodule
